// File: rtl/mul_div_unit.sv
// mul_div_unit: 8-bit unsigned sequential multiply / divide engine.
// One operation at a time. Multiply is an 8-step shift-add and divide is an
// 8-step restoring division. The two result halves are written back over two
// consecutive cycles to a base register index and to the index after it.
module mul_div_unit (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       OP,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] DR_IN,
  output logic       BUSY,
  output logic       WB_LD,
  output logic [2:0] WB_DR,
  output logic [7:0] WB_DATA,
  output logic       DONE,
  output logic       DZ
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } state_t;

  state_t     state_r;
  logic [7:0] a_r;      // captured multiplicand
  logic [7:0] b_r;      // captured divisor
  logic       op_r;     // captured operation select
  logic [2:0] dr_r;     // captured base destination index
  logic [2:0] cnt_r;    // CALC step counter, 0..7
  // Shared datapath register pair:
  //   multiply: {hi_r, lo_r} is the partial product; lo_r starts as the multiplier
  //   divide:   hi_r is the partial remainder; lo_r shifts the dividend out and the quotient in
  logic [7:0] hi_r;
  logic [7:0] lo_r;

  logic [8:0] sum_s;
  logic [8:0] shl_s;
  logic [7:0] hi_nxt_s;
  logic [7:0] lo_nxt_s;

  // One iteration of shift-add multiply or restoring divide on the shared register pair
  always_comb begin
    sum_s    = 9'd0;
    shl_s    = 9'd0;
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (op_r == 1'b0) begin
      sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : 9'd0);
      hi_nxt_s = sum_s[8:1];
      lo_nxt_s = {sum_s[0], lo_r[7:1]};
    end else begin
      shl_s = {hi_r, lo_r[7]};
      if (shl_s >= {1'b0, b_r}) begin
        hi_nxt_s = 8'(shl_s - {1'b0, b_r});
        lo_nxt_s = {lo_r[6:0], 1'b1};
      end else begin
        hi_nxt_s = shl_s[7:0];
        lo_nxt_s = {lo_r[6:0], 1'b0};
      end
    end
  end

  // Control FSM with registered outputs; each output is set on the edge that enters the state it belongs to
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      op_r    <= 1'b0;
      dr_r    <= 3'd0;
      cnt_r   <= 3'd0;
      hi_r    <= 8'h00;
      lo_r    <= 8'h00;
      BUSY    <= 1'b0;
      WB_LD   <= 1'b0;
      WB_DR   <= 3'd0;
      WB_DATA <= 8'h00;
      DONE    <= 1'b0;
      DZ      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          WB_LD <= 1'b0;
          DONE  <= 1'b0;
          if (START) begin
            a_r   <= A;
            b_r   <= B;
            op_r  <= OP;
            dr_r  <= DR_IN;
            cnt_r <= 3'd0;
            BUSY  <= 1'b1;
            if (OP && (B == 8'h00)) begin
              // Divide by zero: skip CALC; quotient all-ones, remainder = dividend
              DZ      <= 1'b1;
              hi_r    <= A;
              lo_r    <= 8'hFF;
              state_r <= ST_WB_LO;
              WB_LD   <= 1'b1;
              WB_DR   <= DR_IN;
              WB_DATA <= 8'hFF;
            end else begin
              DZ      <= 1'b0;
              hi_r    <= 8'h00;
              lo_r    <= OP ? A : B;
              state_r <= ST_CALC;
            end
          end else begin
            BUSY <= 1'b0;
          end
        end
        ST_CALC: begin
          hi_r  <= hi_nxt_s;
          lo_r  <= lo_nxt_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_r <= ST_WB_LO;
            WB_LD   <= 1'b1;
            WB_DR   <= dr_r;
            WB_DATA <= lo_nxt_s;
          end else begin
            WB_LD <= 1'b0;
          end
        end
        ST_WB_LO: begin
          state_r <= ST_WB_HI;
          WB_LD   <= 1'b1;
          DONE    <= 1'b1;
          WB_DR   <= dr_r + 3'd1;
          WB_DATA <= hi_r;
        end
        ST_WB_HI: begin
          // START seen here is deliberately dropped; the next request needs IDLE
          state_r <= ST_IDLE;
          WB_LD   <= 1'b0;
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          WB_LD   <= 1'b0;
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a writeback scoreboard.
module tb_mul_div_unit;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic       OP;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] DR_IN;
  logic       BUSY;
  logic       WB_LD;
  logic [2:0] WB_DR;
  logic [7:0] WB_DATA;
  logic       DONE;
  logic       DZ;

  int checks;
  int failures;

  // expected writebacks, {dr[2:0], data[7:0]}
  logic [10:0] sb_q[$];

  mul_div_unit dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .OP      (OP),
    .A       (A),
    .B       (B),
    .DR_IN   (DR_IN),
    .BUSY    (BUSY),
    .WB_LD   (WB_LD),
    .WB_DR   (WB_DR),
    .WB_DATA (WB_DATA),
    .DONE    (DONE),
    .DZ      (DZ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request and record the two writebacks it must produce
  task automatic drive_start(input logic op, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] dr, input logic [7:0] exp_lo,
                             input logic [7:0] exp_hi);
    logic [2:0] dr_hi;
    dr_hi = dr + 3'd1;
    START = 1'b1;
    OP    = op;
    A     = a;
    B     = b;
    DR_IN = dr;
    sb_q.push_back({dr, exp_lo});
    sb_q.push_back({dr_hi, exp_hi});
  endtask

  // Follow one accepted operation to the first IDLE cycle, checking every cycle
  task automatic wait_op(input string tag, input int exp_busy, input logic exp_dz,
                         input bit repulse, input bit wbhi_start);
    int busy_cnt;
    int wb_cnt;
    logic [10:0] exp_wb;
    busy_cnt = 0;
    wb_cnt   = 0;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!BUSY) break;
      busy_cnt++;
      chk({tag, "_done"}, DONE, (WB_LD && wb_cnt == 1) ? 16'd1 : 16'd0);
      chk({tag, "_dz"}, DZ, exp_dz);
      if (WB_LD) begin
        if (sb_q.size() == 0) begin
          chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
          exp_wb = sb_q.pop_front();
          chk({tag, "_wb_dr"}, WB_DR, exp_wb[10:8]);
          chk({tag, "_wb_data"}, WB_DATA, exp_wb[7:0]);
        end
        wb_cnt++;
        if (wb_cnt == 2 && wbhi_start) begin
          drive_start(1'b0, 8'd6, 8'd7, 3'd2, 8'h2A, 8'h00);
        end
      end
      if (repulse && i == 2) begin
        START = 1'b1;
        OP    = ~OP;
        A     = 8'h33;
        B     = 8'h00;
        DR_IN = DR_IN + 3'd3;
      end else if (repulse && i == 3) begin
        START = 1'b0;
      end
      @(negedge CLK);
    end
    chk({tag, "_busy_cycles"}, 16'(busy_cnt), 16'(exp_busy));
    chk({tag, "_wb_count"}, 16'(wb_cnt), 16'd2);
    chk({tag, "_idle_wb_ld"}, WB_LD, 16'd0);
    chk({tag, "_dz_end"}, DZ, exp_dz);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    START    = 1'b0;
    OP       = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    DR_IN    = 3'd0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 16'd0);
    chk("rst_wb_ld", WB_LD, 16'd0);
    chk("rst_done", DONE, 16'd0);
    chk("rst_dz", DZ, 16'd0);
    chk("rst_wb_dr", WB_DR, 16'd0);
    chk("rst_wb_data", WB_DATA, 16'd0);
    RESET_N = 1'b1;

    // 13*11 = 0x008F
    @(negedge CLK);
    drive_start(1'b0, 8'd13, 8'd11, 3'd3, 8'h8F, 8'h00);
    wait_op("mul13x11", 10, 1'b0, 1'b0, 1'b0);

    // 0xFF*0xFF = 0xFE01, destination index wraps 7 -> 0
    @(negedge CLK);
    drive_start(1'b0, 8'hFF, 8'hFF, 3'd7, 8'h01, 8'hFE);
    wait_op("mulFFxFF", 10, 1'b0, 1'b0, 1'b0);

    // 200/7 = 28 r 4
    @(negedge CLK);
    drive_start(1'b1, 8'd200, 8'd7, 3'd1, 8'h1C, 8'h04);
    wait_op("div200by7", 10, 1'b0, 1'b0, 1'b0);

    // divide by zero
    @(negedge CLK);
    drive_start(1'b1, 8'h55, 8'h00, 3'd5, 8'hFF, 8'h55);
    wait_op("divzero", 2, 1'b1, 1'b0, 1'b0);
    // DZ and last writeback values hold while idle
    repeat (3) @(negedge CLK);
    chk("dz_hold", DZ, 16'd1);
    chk("hold_wb_ld", WB_LD, 16'd0);
    chk("hold_wb_dr", WB_DR, 16'd6);
    chk("hold_wb_data", WB_DATA, 16'h55);

    // START re-pulsed in CALC cycle 3 is ignored; 156*59 = 0x23F4
    drive_start(1'b0, 8'd156, 8'd59, 3'd2, 8'hF4, 8'h23);
    wait_op("mul_repulse", 10, 1'b0, 1'b1, 1'b0);

    // 5/9 = 0 r 5, index wrap
    @(negedge CLK);
    drive_start(1'b1, 8'd5, 8'd9, 3'd7, 8'h00, 8'h05);
    wait_op("div5by9", 10, 1'b0, 1'b0, 1'b0);

    // START raised during WB_HI must wait for IDLE; 255/16 = 15 r 15, then 6*7 = 42
    @(negedge CLK);
    drive_start(1'b1, 8'hFF, 8'h10, 3'd6, 8'h0F, 8'h0F);
    wait_op("div_wbhi", 10, 1'b0, 1'b0, 1'b1);
    chk("wbhi_idle_gap", BUSY, 16'd0);
    wait_op("mul_after_wbhi", 10, 1'b0, 1'b0, 1'b0);

    // reset during CALC cycle 4 aborts with no writeback
    @(negedge CLK);
    drive_start(1'b1, 8'd100, 8'd3, 3'd4, 8'd33, 8'd1);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_rst_busy", BUSY, 16'd1);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_busy", BUSY, 16'd0);
    chk("async_rst_wb_ld", WB_LD, 16'd0);
    chk("async_rst_done", DONE, 16'd0);
    chk("async_rst_wb_dr", WB_DR, 16'd0);
    chk("async_rst_wb_data", WB_DATA, 16'd0);
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rst_hold_wb_ld", WB_LD, 16'd0);
    end
    // accepted at the first rising edge after release: 165*2 = 0x014A
    RESET_N = 1'b1;
    drive_start(1'b0, 8'hA5, 8'h02, 3'd0, 8'h4A, 8'h01);
    wait_op("mul_after_rst", 10, 1'b0, 1'b0, 1'b0);

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; the datapath width is fixed at 8 bits.
REQ-002 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 START  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 OP  input  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 A  input  8  first operand (multiplicand or dividend), driven from register-file read port A.
REQ-007 B  input  8  second operand (multiplier or divisor), driven from register-file read port B.
REQ-008 DR_IN  input  3  base destination register index.
REQ-009 BUSY  output  1  high from the cycle after START is accepted until the last writeback cycle, inclusive.
REQ-010 WB_LD  output  1  register-file write enable.
REQ-011 WB_DR  output  3  register-file destination index.
REQ-012 WB_DATA  output  8  register-file write data.
REQ-013 DONE  output  1  single-cycle completion pulse.
REQ-014 DZ  output  1  divide-by-zero flag.

Function
REQ-015 All outputs SHALL be driven from registers; no combinational path from any input to any output.
REQ-016 States SHALL be IDLE, CALC, WB_LO and WB_HI.
REQ-017 In IDLE with START=1 at a rising edge, the block SHALL capture A, B, OP and DR_IN, clear DZ, and leave IDLE.
- Next state is CALC.
- Exception: OP=1 with B=0 goes directly to WB_LO (REQ-022).
REQ-018 While BUSY=1, START and all operand inputs SHALL be ignored; the captured values are used throughout the operation.
REQ-019 CALC SHALL last exactly 8 cycles, processing one bit per cycle (an 8-step shift-add or restoring-divide iteration), then go to WB_LO.
REQ-020 Multiply SHALL produce the full 16-bit unsigned product.
- WB_LO writes P[7:0].
- WB_HI writes P[15:8].
REQ-021 Divide SHALL produce an 8-bit quotient and an 8-bit remainder.
- WB_LO writes the quotient.
- WB_HI writes the remainder.
REQ-022 Divide with a captured B of 0 SHALL skip CALC and set DZ=1.
- WB_LO writes 8'hFF.
- WB_HI writes the captured dividend.
REQ-023 WB_LO SHALL last one cycle with WB_LD=1 and WB_DR=captured DR_IN, then go to WB_HI.
REQ-024 WB_HI SHALL last one cycle with WB_LD=1 and DONE=1.
- WB_DR = (captured DR_IN + 1) mod 8; index 7 wraps to 0.
- Next state is IDLE.
REQ-025 WB_LD and DONE SHALL be 0 in every cycle other than those stated in REQ-023 and REQ-024.
REQ-026 WB_DR and WB_DATA SHALL hold their last values when WB_LD=0.
REQ-027 BUSY latency: 10 cycles for a normal operation; 2 cycles for divide-by-zero.
REQ-028 A START asserted in the same cycle as WB_HI SHALL be ignored; a new request is accepted no earlier than the first IDLE cycle.
REQ-029 DZ SHALL remain stable from its setting until the next accepted START.

Reset
REQ-030 RESET_N=0 SHALL immediately, without waiting for a clock edge, force the following:
- state = IDLE;
- BUSY = 0, WB_LD = 0, DONE = 0, DZ = 0;
- WB_DR = 3'b000, WB_DATA = 8'h00;
- all internal accumulators and counters = 0.
REQ-031 Reset asserted mid-operation in any state SHALL abort the operation with no further WB_LD pulse.
REQ-032 After RESET_N deasserts, the block SHALL accept START at the first rising edge.

Verification
REQ-033 Multiply: OP=0, A=13, B=11, DR_IN=3 -> after 8 CALC cycles, WB_LD writes 8'h8F to R3, then 8'h00 to R4 with DONE=1; BUSY high 10 cycles.
REQ-034 Multiply with wrap: OP=0, A=8'hFF, B=8'hFF, DR_IN=7 -> writes 8'h01 to R7, then 8'hFE to R0.
REQ-035 Divide: OP=1, A=200, B=7, DR_IN=1 -> writes 8'h1C to R1, then 8'h04 to R2; DZ=0.
REQ-036 Divide-by-zero: OP=1, A=8'h55, B=0, DR_IN=5 -> BUSY 2 cycles; writes 8'hFF to R5, then 8'h55 to R6; DZ=1 until the next accepted START.
REQ-037 Busy and reset: START re-pulsed during CALC cycle 3 with different operands -> ignored, original result written. Then RESET_N pulsed low during CALC cycle 4 of a new operation -> BUSY=0 immediately, no WB_LD, and the next START completes normally.
